// File: rtl/nmi_arb2.sv
// Two-master round-robin arbiter on the native memory interface; grant held per transaction.
// Optional watchdog timeout enabled by defining NMI_ARB_TIMEOUT_EN.
module nmi_arb2 #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    m0_valid_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb_i,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  output logic                    m0_ready_o,
  input  logic                    m1_valid_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb_i,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    m1_ready_o,
  output logic                    s_valid_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  output logic [DATA_WIDTH/8-1:0] s_wstrb_o,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  input  logic                    s_ready_i,
  output logic [1:0]              gnt_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  localparam logic [DATA_WIDTH-1:0] TIMEOUT_RDATA = DATA_WIDTH'(32'hDEAD_BEEF);

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   to_hit;

`ifdef NMI_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counter is held at zero outside a grant, so every grant starts from zero.
  always_comb begin
    cnt_d = 16'd0;
    if (state_q != IDLE && !s_ready_i) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= 16'd0;
    else          cnt_q <= cnt_d;
  end

  assign to_hit = (cnt_q == 16'(TIMEOUT_CYC - 1)) && !s_ready_i;
`else
  logic [15:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 16'(TIMEOUT_CYC);
  assign to_hit             = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    s_valid_o  = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
    m0_ready_o = 1'b0;
    m0_rdata_o = '0;
    m1_ready_o = 1'b0;
    m1_rdata_o = '0;
    err_o      = 1'b0;
    case (state_q)
      IDLE: begin
        // With both requesting, the master not served last wins.
        if (m0_valid_i && m1_valid_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_valid_i)          state_d = GNT0;
        else if (m1_valid_i)          state_d = GNT1;
      end
      GNT0: begin
        s_valid_o  = m0_valid_i;
        s_addr_o   = m0_addr_i;
        s_wdata_o  = m0_wdata_i;
        s_wstrb_o  = m0_wstrb_i;
        m0_ready_o = s_ready_i;
        m0_rdata_o = s_rdata_i;
        if (s_ready_i) begin
          last_d  = 1'b0;
          state_d = IDLE;
        end else if (!m0_valid_i) begin
          state_d = IDLE;
        end else if (to_hit) begin
          m0_ready_o = 1'b1;
          m0_rdata_o = TIMEOUT_RDATA;
          err_o      = 1'b1;
          last_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      GNT1: begin
        s_valid_o  = m1_valid_i;
        s_addr_o   = m1_addr_i;
        s_wdata_o  = m1_wdata_i;
        s_wstrb_o  = m1_wstrb_i;
        m1_ready_o = s_ready_i;
        m1_rdata_o = s_rdata_i;
        if (s_ready_i) begin
          last_d  = 1'b1;
          state_d = IDLE;
        end else if (!m1_valid_i) begin
          state_d = IDLE;
        end else if (to_hit) begin
          m1_ready_o = 1'b1;
          m1_rdata_o = TIMEOUT_RDATA;
          err_o      = 1'b1;
          last_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o = {state_q == GNT1, state_q == GNT0};

endmodule
